fifo_write_arbiter: RTL and testbench

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

---
 rtl/fifo_write_arbiter.sv | 111 +++++++++++
 tb/tb_fifo_write_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter that lets one of NumReq requesters stream packets into a FIFO write port.
// A grant is held until end-of-packet or MaxBurst beats, then priority rotates past the winner.
module fifo_write_arbiter #(
    parameter int DepthSize = 8,
    parameter int NumReq    = 4,
    parameter int MaxBurst  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NumReq-1:0]           req,
    input  logic [NumReq-1:0]           last,
    input  logic [NumReq*DepthSize-1:0] data,
    output logic [NumReq-1:0]           ack,
    input  logic                        wfull,
    output logic                        wreq,
    output logic [DepthSize-1:0]        wdata,
    output logic                        gnt_vld,
    output logic [2:0]                  gnt_id
);

    localparam int CntW = $clog2(MaxBurst + 1);
    localparam logic [NumReq-1:0] OneHot0 = {{(NumReq-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state, state_nxt;
    logic [2:0]        rr_ptr, rr_ptr_nxt, gnt_id_nxt;
    logic [CntW-1:0]   beat_cnt, beat_cnt_nxt;
    logic [NumReq-1:0] gnt_oh;
    logic [2:0]        pick;
    logic              any_req;
    logic              busy, req_g, last_g, beat, release_g;
    logic [DepthSize-1:0] data_g;

    assign gnt_oh = OneHot0 << gnt_id;
    assign req_g  = |(req & gnt_oh);
    assign last_g = |(last & gnt_oh);

    // First set req bit searched cyclically starting just after rr_ptr.
    always_comb begin
        int off;
        logic [NumReq-1:0] mask;
        off     = 0;
        mask    = '0;
        any_req = 1'b0;
        for (int j = NumReq - 1; j >= 0; j--) begin
            mask = OneHot0 << ((int'(rr_ptr) + 1 + j) % NumReq);
            if (|(req & mask)) begin
                any_req = 1'b1;
                off     = j;
            end
        end
        pick = 3'((int'(rr_ptr) + 1 + off) % NumReq);
    end

    always_comb begin
        data_g = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (gnt_oh[i]) data_g = data[i*DepthSize +: DepthSize];
        end
    end

    // Outputs are forced quiet while reset is asserted so no beat slips through.
    assign busy      = (state == BUSY) && !rst;
    assign beat      = busy && req_g && !wfull;
    assign release_g = beat && (last_g || (beat_cnt == CntW'(MaxBurst - 1)));

    assign gnt_vld = busy;
    assign wreq    = beat;
    assign ack     = beat ? gnt_oh : '0;
    assign wdata   = busy ? data_g : '0;

    always_comb begin
        state_nxt    = state;
        gnt_id_nxt   = gnt_id;
        rr_ptr_nxt   = rr_ptr;
        beat_cnt_nxt = beat_cnt;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt    = BUSY;
                    gnt_id_nxt   = pick;
                    beat_cnt_nxt = '0;
                end
            end
            BUSY: begin
                if (beat) beat_cnt_nxt = beat_cnt + 1'b1;
                if (release_g) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = gnt_id;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt_id   <= 3'd0;
            beat_cnt <= '0;
            rr_ptr   <= 3'(NumReq - 1);
        end else begin
            state    <= state_nxt;
            gnt_id   <= gnt_id_nxt;
            beat_cnt <= beat_cnt_nxt;
            rr_ptr   <= rr_ptr_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed and randomized checks of fifo_write_arbiter; a second instance uses MaxBurst=4.
module tb_fifo_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, last;
    logic [31:0] data;
    logic        wfull;
    logic [3:0]  ack, ack4;
    logic        wreq, wreq4, gnt_vld, gnt_vld4;
    logic [7:0]  wdata, wdata4;
    logic [2:0]  gnt_id, gnt_id4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_write_arbiter #(.DepthSize(8), .NumReq(4), .MaxBurst(16)) dut (
        .clk(clk), .rst(rst), .req(req), .last(last), .data(data), .ack(ack),
        .wfull(wfull), .wreq(wreq), .wdata(wdata), .gnt_vld(gnt_vld), .gnt_id(gnt_id)
    );

    fifo_write_arbiter #(.DepthSize(8), .NumReq(4), .MaxBurst(4)) dut4 (
        .clk(clk), .rst(rst), .req(req), .last(last), .data(data), .ack(ack4),
        .wfull(wfull), .wreq(wreq4), .wdata(wdata4), .gnt_vld(gnt_vld4), .gnt_id(gnt_id4)
    );

    task automatic test_reset;
        rst = 1'b1; req = 4'hF; last = 4'h0; wfull = 1'b0; data = 32'hDEADBEEF;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++; if (gnt_vld !== 1'b0) begin errors++; $display("FAIL rst_gnt_vld got %0h want 0", gnt_vld); end
        checks++; if (wreq !== 1'b0) begin errors++; $display("FAIL rst_wreq got %0h want 0", wreq); end
        checks++; if (ack !== 4'h0) begin errors++; $display("FAIL rst_ack got %0h want 0", ack); end
        checks++; if (wdata !== 8'h00) begin errors++; $display("FAIL rst_wdata got %0h want 0", wdata); end
        rst = 1'b0; req = 4'h0; data = 32'h0;
        @(negedge clk); #1;
        checks++; if (gnt_vld !== 1'b0) begin errors++; $display("FAIL post_rst_gnt_vld got %0h want 0", gnt_vld); end
        checks++; if (gnt_id !== 3'd0) begin errors++; $display("FAIL post_rst_gnt_id got %0h want 0", gnt_id); end
        @(negedge clk);
    endtask

    task automatic test_round_robin;
        logic       exp_vld [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0] exp_id  [6] = '{3'd0, 3'd1, 3'd0, 3'd3, 3'd0, 3'd1};
        req = 4'b1010; last = 4'b1010; wfull = 1'b0; data = 32'hA3A2A1A0;
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++; if (gnt_vld !== exp_vld[c]) begin errors++; $display("FAIL rr_gnt_vld[%0d] got %0h want %0h", c, gnt_vld, exp_vld[c]); end
            if (exp_vld[c]) begin
                checks++; if (gnt_id !== exp_id[c]) begin errors++; $display("FAIL rr_gnt_id[%0d] got %0h want %0h", c, gnt_id, exp_id[c]); end
                checks++; if (ack !== (4'b1 << exp_id[c])) begin errors++; $display("FAIL rr_ack[%0d] got %0h want %0h", c, ack, 4'b1 << exp_id[c]); end
                checks++; if (wdata !== (8'hA0 + 8'(exp_id[c]))) begin errors++; $display("FAIL rr_wdata[%0d] got %0h want %0h", c, wdata, 8'hA0 + 8'(exp_id[c])); end
            end else begin
                checks++; if (wreq !== 1'b0 || ack !== 4'h0) begin errors++; $display("FAIL rr_idle_out[%0d] got wreq %0h ack %0h want 0", c, wreq, ack); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_packet;
        req = 4'b0101; last = 4'b0000; wfull = 1'b0; data = 32'h0;
        data[7:0] = 8'h55; data[23:16] = 8'h10;
        #1;
        checks++; if (gnt_vld !== 1'b0) begin errors++; $display("FAIL pkt_idle got %0h want 0", gnt_vld); end
        @(negedge clk);
        for (int b = 0; b < 5; b++) begin
            data[23:16] = 8'h10 + 8'(b);
            last = (b == 4) ? 4'b0100 : 4'b0000;
            #1;
            checks++; if (gnt_id !== 3'd2) begin errors++; $display("FAIL pkt_gnt_id[%0d] got %0h want 2", b, gnt_id); end
            checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL pkt_ack[%0d] got %0h want 4", b, ack); end
            checks++; if (wdata !== 8'h10 + 8'(b)) begin errors++; $display("FAIL pkt_wdata[%0d] got %0h want %0h", b, wdata, 8'h10 + 8'(b)); end
            @(negedge clk);
        end
        last = 4'b0001;
        #1;
        checks++; if (gnt_vld !== 1'b0 || ack !== 4'h0) begin errors++; $display("FAIL pkt_gap got vld %0h ack %0h want 0", gnt_vld, ack); end
        @(negedge clk); #1;
        checks++; if (gnt_id !== 3'd0 || gnt_vld !== 1'b1) begin errors++; $display("FAIL pkt_next_gnt got id %0h vld %0h want id 0 vld 1", gnt_id, gnt_vld); end
        checks++; if (ack !== 4'b0001 || wdata !== 8'h55) begin errors++; $display("FAIL pkt_next_beat got ack %0h wdata %0h want 1 55", ack, wdata); end
        @(negedge clk);
    endtask

    task automatic test_wfull;
        logic pat [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        int   eb = 0;
        logic [7:0] exp_d;
        req = 4'b0010; last = 4'b0000; wfull = 1'b0; data = 32'h0;
        #1;
        checks++; if (gnt_vld !== 1'b0) begin errors++; $display("FAIL wf_idle got %0h want 0", gnt_vld); end
        @(negedge clk);
        for (int k = 0; k < 7; k++) begin
            exp_d = 8'h40 + 8'(eb);
            wfull = pat[k];
            data[15:8] = exp_d;
            last = (eb == 3) ? 4'b0010 : 4'b0000;
            #1;
            checks++; if (gnt_vld !== 1'b1 || gnt_id !== 3'd1) begin errors++; $display("FAIL wf_grant[%0d] got vld %0h id %0h want 1 1", k, gnt_vld, gnt_id); end
            checks++; if (wreq !== !pat[k]) begin errors++; $display("FAIL wf_wreq[%0d] got %0h want %0h", k, wreq, !pat[k]); end
            checks++; if (ack !== (pat[k] ? 4'b0000 : 4'b0010)) begin errors++; $display("FAIL wf_ack[%0d] got %0h want %0h", k, ack, pat[k] ? 4'b0000 : 4'b0010); end
            checks++; if (wdata !== exp_d) begin errors++; $display("FAIL wf_wdata[%0d] got %0h want %0h", k, wdata, exp_d); end
            if (!pat[k]) eb++;
            @(negedge clk);
        end
        wfull = 1'b0; req = 4'b0000; last = 4'b0000;
        #1;
        checks++; if (gnt_vld !== 1'b0) begin errors++; $display("FAIL wf_release got %0h want 0", gnt_vld); end
        @(negedge clk);
    endtask

    task automatic test_max_burst;
        logic [3:0] exp_ack [8] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h0, 4'h1};
        rst = 1'b1; req = 4'h0; last = 4'h0; wfull = 1'b0;
        @(negedge clk);
        rst = 1'b0; req = 4'b0011; last = 4'b0010; data = 32'h0000_6160;
        #1;
        checks++; if (gnt_vld4 !== 1'b0) begin errors++; $display("FAIL mb_idle got %0h want 0", gnt_vld4); end
        @(negedge clk);
        for (int c = 0; c < 8; c++) begin
            #1;
            checks++; if (ack4 !== exp_ack[c]) begin errors++; $display("FAIL mb_ack[%0d] got %0h want %0h", c, ack4, exp_ack[c]); end
            checks++; if (gnt_vld4 !== (|exp_ack[c])) begin errors++; $display("FAIL mb_gnt_vld[%0d] got %0h want %0h", c, gnt_vld4, |exp_ack[c]); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid;
        rst = 1'b1; req = 4'h0; last = 4'h0; wfull = 1'b0;
        @(negedge clk);
        rst = 1'b0; req = 4'hF; data = 32'h83828180;
        #1;
        checks++; if (gnt_vld !== 1'b0) begin errors++; $display("FAIL rm_idle got %0h want 0", gnt_vld); end
        @(negedge clk); #1;
        checks++; if (gnt_id !== 3'd0 || ack !== 4'b0001) begin errors++; $display("FAIL rm_beat1 got id %0h ack %0h want 0 1", gnt_id, ack); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (wreq !== 1'b0 || ack !== 4'h0) begin errors++; $display("FAIL rm_in_reset got wreq %0h ack %0h want 0", wreq, ack); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (gnt_vld !== 1'b0 || wreq !== 1'b0 || ack !== 4'h0) begin errors++; $display("FAIL rm_after_edge got vld %0h wreq %0h ack %0h want 0", gnt_vld, wreq, ack); end
        @(negedge clk); #1;
        checks++; if (gnt_vld !== 1'b1 || gnt_id !== 3'd0) begin errors++; $display("FAIL rm_regrant got vld %0h id %0h want 1 0", gnt_vld, gnt_id); end
        checks++; if (wdata !== 8'h80) begin errors++; $display("FAIL rm_wdata got %0h want 80", wdata); end
        @(negedge clk);
    endtask

    task automatic test_random;
        logic [7:0] cnt [4];
        rst = 1'b1; req = 4'h0; last = 4'h0; wfull = 1'b0;
        for (int i = 0; i < 4; i++) cnt[i] = 8'h0;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            req   = 4'($urandom);
            last  = 4'($urandom);
            wfull = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 4; i++) data[i*8 +: 8] = cnt[i];
            #1;
            checks++; if (!$onehot0(ack)) begin errors++; $display("FAIL rnd_onehot[%0d] got %0h want one-hot or 0", n, ack); end
            checks++; if (wreq && wfull) begin errors++; $display("FAIL rnd_overflow[%0d] got wreq 1 want 0 while full", n); end
            checks++; if (wreq !== (|ack)) begin errors++; $display("FAIL rnd_wreq_ack[%0d] got wreq %0h ack %0h", n, wreq, ack); end
            if (wreq) begin
                checks++; if (ack !== (4'b1 << gnt_id) || wdata !== cnt[gnt_id[1:0]]) begin
                    errors++; $display("FAIL rnd_order[%0d] got ack %0h wdata %0h want ack %0h wdata %0h", n, ack, wdata, 4'b1 << gnt_id, cnt[gnt_id[1:0]]);
                end
            end
            for (int i = 0; i < 4; i++) if (ack[i]) cnt[i] = cnt[i] + 8'd1;
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; req = 4'h0; last = 4'h0; data = 32'h0; wfull = 1'b0;
        test_reset();
        test_round_robin();
        test_packet();
        test_wfull();
        test_max_burst();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
